// File: rtl/load_align_unit.sv
// Sequential load formatter: aligned memory reads, merge, byte extract, sign/zero extend.
module load_align_unit #(
  parameter int unsigned XLEN          = 32,
  parameter bit          MISALIGNED_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [2:0]      width_src_i,
  input  logic            flush_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            fault_o,
  output logic            misaligned_o
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    RSP0  = 3'd2,
    REQ1  = 3'd3,
    RSP1  = 3'd4,
    DONE  = 3'd5,
    DRAIN = 3'd6
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] addr_q;
  logic [2:0]      width_q;
  logic [XLEN-1:0] word0_q;

  logic [3:0]      size_req, size_q;
  logic            split_req, split_q;
  logic [XLEN-1:0] aligned;
  logic [XLEN-1:0] low, mask, ext;
  logic            sbit;

  // Access size in bytes; 0 marks an illegal load type for this XLEN.
  function automatic logic [3:0] load_size(input logic [2:0] w);
    case (w)
      3'b000:  return 4'd4;
      3'b100:  return (XLEN == 64) ? 4'd4 : 4'd0;
      3'b011:  return (XLEN == 64) ? 4'd8 : 4'd0;
      3'b010,
      3'b110:  return 4'd2;
      3'b001,
      3'b101:  return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  always_comb begin
    size_req  = load_size(width_src_i);
    size_q    = load_size(width_q);
    split_req = (5'(req_addr_i[OFFW-1:0]) + 5'(size_req)) > 5'(NB);
    split_q   = (5'(addr_q[OFFW-1:0]) + 5'(size_q)) > 5'(NB);
    aligned   = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (size_req == 4'd0 || (split_req && !MISALIGNED_EN)) state_next = DONE;
          else                                                    state_next = REQ0;
        end
      end
      REQ0: begin
        if (flush_i)              state_next = IDLE;
        else if (mem_req_ready_i) state_next = RSP0;
      end
      RSP0: begin
        if (flush_i)           state_next = mem_rvalid_i ? IDLE : DRAIN;
        else if (mem_rvalid_i) state_next = split_q ? REQ1 : DONE;
      end
      REQ1: begin
        if (flush_i)              state_next = IDLE;
        else if (mem_req_ready_i) state_next = RSP1;
      end
      RSP1: begin
        if (flush_i)           state_next = mem_rvalid_i ? IDLE : DRAIN;
        else if (mem_rvalid_i) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      DRAIN:   if (mem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = (state == IDLE);
    mem_req_valid_o = (state == REQ0) || (state == REQ1);
    mem_addr_o      = '0;
    if (state == REQ0)      mem_addr_o = aligned;
    else if (state == REQ1) mem_addr_o = aligned + XLEN'(NB);
  end

  // The final word is merged straight from mem_rdata_i so the result can be
  // registered on the same edge that enters DONE.
  always_comb begin
    if (state == RSP1) low = XLEN'({mem_rdata_i, word0_q} >> {addr_q[OFFW-1:0], 3'b000});
    else               low = XLEN'({{XLEN{1'b0}}, mem_rdata_i} >> {addr_q[OFFW-1:0], 3'b000});
    case (size_q)
      4'd1:    begin mask = XLEN'(8'hFF);         sbit = low[7];      end
      4'd2:    begin mask = XLEN'(16'hFFFF);      sbit = low[15];     end
      4'd4:    begin mask = XLEN'(32'hFFFF_FFFF); sbit = low[31];     end
      default: begin mask = '1;                   sbit = low[XLEN-1]; end
    endcase
    ext = (low & mask) | ((!width_q[2] && sbit) ? ~mask : '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q         <= '0;
      width_q        <= '0;
      word0_q        <= '0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      fault_o        <= 1'b0;
      misaligned_o   <= 1'b0;
    end else begin
      result_valid_o <= (state_next == DONE);
      if (state == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        width_q <= width_src_i;
      end
      if (state == RSP0 && mem_rvalid_i) word0_q <= mem_rdata_i;
      if (state_next == DONE) begin
        if (state == IDLE) begin
          result_o     <= '0;
          fault_o      <= 1'b1;
          misaligned_o <= 1'b0;
        end else begin
          result_o     <= ext;
          fault_o      <= 1'b0;
          misaligned_o <= (state == RSP1);
        end
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, flush;
  logic [31:0] req_addr;
  logic [2:0]  width;
  logic        mem_req_valid, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        result_valid, fault, mis;
  logic [31:0] result;

  logic        b_req_valid, b_req_ready, b_flush;
  logic [31:0] b_req_addr;
  logic [2:0]  b_width;
  logic        b_mem_req_valid, b_mem_ready, b_mem_rvalid;
  logic [31:0] b_mem_addr, b_mem_rdata;
  logic        b_result_valid, b_fault, b_mis;
  logic [31:0] b_result;

  load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .width_src_i(width), .flush_i(flush),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .result_valid_o(result_valid),
    .result_o(result), .fault_o(fault), .misaligned_o(mis)
  );

  load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) dut_nomis (
    .clk_i(clk), .reset_n_i(rst_n), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_addr_i(b_req_addr), .width_src_i(b_width), .flush_i(b_flush),
    .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(b_mem_ready), .mem_addr_o(b_mem_addr),
    .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(b_mem_rdata), .result_valid_o(b_result_valid),
    .result_o(b_result), .fault_o(b_fault), .misaligned_o(b_mis)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  width;
    logic [31:0] w0, w1;
    int unsigned stall, rdly;
    logic [31:0] res;
    logic        fault, mis;
    int unsigned lat, nrd;
    logic [31:0] a0, a1;
  } vec_t;

  int unsigned applied    = 0;
  int unsigned miscompares = 0;
  vec_t        tbl[18];

  function automatic vec_t mk(input logic [31:0] a, input logic [2:0] w,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input int unsigned st, input int unsigned rd,
                              input logic [31:0] res, input logic f, input logic m,
                              input int unsigned lat, input int unsigned nrd,
                              input logic [31:0] a0, input logic [31:0] a1);
    vec_t v;
    v.addr = a; v.width = w; v.w0 = w0; v.w1 = w1; v.stall = st; v.rdly = rd;
    v.res = res; v.fault = f; v.mis = m; v.lat = lat; v.nrd = nrd; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [2:0] w);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; width = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned cyc = 0, nrd = 0, lat = 0, dly = 0, stall_left;
    logic        pending = 1'b0, got = 1'b0, stalled = 1'b0;
    logic [31:0] ra0 = '0, ra1 = '0, saddr = '0, r_res = '0;
    logic        r_f = 1'b0, r_m = 1'b0;
    stall_left = v.stall;
    start_req(v.addr, v.width);
    while (!got && cyc < 40) begin
      cyc++;
      mem_rvalid = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (nrd == 1) ? v.w0 : v.w1;
          pending    = 1'b0;
        end else dly--;
      end
      mem_ready = 1'b1;
      if (mem_req_valid) begin
        if (stalled) chk($sformatf("v%0d.addr_stable", idx), mem_addr, saddr);
        if (stall_left > 0) begin
          mem_ready = 1'b0; stall_left--; stalled = 1'b1; saddr = mem_addr;
        end else begin
          stalled = 1'b0;
          if (nrd == 0) ra0 = mem_addr;
          else          ra1 = mem_addr;
          nrd++; pending = 1'b1; dly = v.rdly;
        end
      end
      if (result_valid) begin
        got = 1'b1; lat = cyc; r_res = result; r_f = fault; r_m = mis;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    if (!got) begin
      applied++; miscompares++;
      $display("FAIL v%0d.timeout: got no result_valid_o, want one within 40 cycles", idx);
    end else begin
      chk($sformatf("v%0d.result", idx), r_res, v.res);
      chk($sformatf("v%0d.fault", idx), 32'(r_f), 32'(v.fault));
      chk($sformatf("v%0d.misaligned", idx), 32'(r_m), 32'(v.mis));
      chk($sformatf("v%0d.latency", idx), lat, v.lat);
      chk($sformatf("v%0d.reads", idx), nrd, v.nrd);
      if (v.nrd >= 1) chk($sformatf("v%0d.addr0", idx), ra0, v.a0);
      if (v.nrd >= 2) chk($sformatf("v%0d.addr1", idx), ra1, v.a1);
      chk($sformatf("v%0d.pulse", idx), 32'(result_valid), 32'd0);
      chk($sformatf("v%0d.ready_after", idx), 32'(req_ready), 32'd1);
      chk($sformatf("v%0d.hold", idx), result, v.res);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; width = '0; flush = 1'b0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_width = '0; b_flush = 1'b0;
    b_mem_ready = 1'b1; b_mem_rvalid = 1'b0; b_mem_rdata = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst.result_valid", 32'(result_valid), 32'd0);
    chk("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.misaligned", 32'(mis), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    //             addr          w       w0            w1            st rd res           f     m     lat nrd a0            a1
    tbl[0]  = mk(32'h0000_1000, 3'b000, 32'hDEADBEEF, 32'h0,       0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[1]  = mk(32'h0000_1003, 3'b001, 32'h80FF1234, 32'h0,       0, 0, 32'hFFFFFF80, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[2]  = mk(32'h0000_1003, 3'b101, 32'h80FF1234, 32'h0,       0, 0, 32'h00000080, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[3]  = mk(32'h0000_1002, 3'b000, 32'h44332211, 32'h88776655, 0, 0, 32'h66554433, 1'b0, 1'b1, 5, 2, 32'h0000_1000, 32'h0000_1004);
    tbl[4]  = mk(32'h0000_1003, 3'b010, 32'h44332211, 32'h887766F5, 0, 0, 32'hFFFFF544, 1'b0, 1'b1, 5, 2, 32'h0000_1000, 32'h0000_1004);
    tbl[5]  = mk(32'h0000_1003, 3'b110, 32'h44332211, 32'h887766F5, 0, 0, 32'h0000F544, 1'b0, 1'b1, 5, 2, 32'h0000_1000, 32'h0000_1004);
    tbl[6]  = mk(32'hFFFF_FFFE, 3'b000, 32'hAABBCCDD, 32'h11223344, 0, 0, 32'h3344AABB, 1'b0, 1'b1, 5, 2, 32'hFFFF_FFFC, 32'h0000_0000);
    tbl[7]  = mk(32'h0000_2000, 3'b011, 32'h0,        32'h0,       0, 0, 32'h00000000, 1'b1, 1'b0, 1, 0, 32'h0,         32'h0);
    tbl[8]  = mk(32'h0000_2000, 3'b100, 32'h0,        32'h0,       0, 0, 32'h00000000, 1'b1, 1'b0, 1, 0, 32'h0,         32'h0);
    tbl[9]  = mk(32'h0000_2000, 3'b111, 32'h0,        32'h0,       0, 0, 32'h00000000, 1'b1, 1'b0, 1, 0, 32'h0,         32'h0);
    tbl[10] = mk(32'h0000_1002, 3'b010, 32'h7FFF0000, 32'h0,       0, 0, 32'h00007FFF, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[11] = mk(32'h0000_1000, 3'b110, 32'h1234ABCD, 32'h0,       0, 0, 32'h0000ABCD, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[12] = mk(32'h0000_1000, 3'b010, 32'h1234ABCD, 32'h0,       0, 0, 32'hFFFFABCD, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[13] = mk(32'h0000_1001, 3'b001, 32'h1234ABCD, 32'h0,       0, 0, 32'hFFFFFFAB, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[14] = mk(32'h0000_1001, 3'b010, 32'h1234ABCD, 32'h0,       0, 0, 32'h000034AB, 1'b0, 1'b0, 3, 1, 32'h0000_1000, 32'h0);
    tbl[15] = mk(32'h0000_2000, 3'b000, 32'hCAFEF00D, 32'h0,       2, 1, 32'hCAFEF00D, 1'b0, 1'b0, 6, 1, 32'h0000_2000, 32'h0);
    tbl[16] = mk(32'h0000_2006, 3'b000, 32'h11223344, 32'h55667788, 1, 1, 32'h77881122, 1'b0, 1'b1, 8, 2, 32'h0000_2004, 32'h0000_2008);
    tbl[17] = mk(32'h0000_2007, 3'b001, 32'h7F000000, 32'h0,       0, 0, 32'h0000007F, 1'b0, 1'b0, 3, 1, 32'h0000_2004, 32'h0);

    for (int i = 0; i < 18; i++) run_vec(i, tbl[i]);

    // flush in RSP0, response arrives two cycles later
    start_req(32'h0000_1000, 3'b000);
    chk("flush_rsp.req0", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_rsp.drain_ready", 32'(req_ready), 32'd0);
    chk("flush_rsp.no_valid1", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    chk("flush_rsp.still_drain", 32'(req_ready), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("flush_rsp.ready", 32'(req_ready), 32'd1);
    chk("flush_rsp.no_valid2", 32'(result_valid), 32'd0);
    chk("flush_rsp.result_hold", result, 32'h0000007F);

    // flush together with rvalid: flush wins, straight to IDLE
    start_req(32'h0000_1000, 3'b000);
    @(posedge clk); #1;
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666;
    @(posedge clk); #1;
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("flush_rv.ready", 32'(req_ready), 32'd1);
    chk("flush_rv.no_valid", 32'(result_valid), 32'd0);

    // flush in REQ0 while memory is stalling
    start_req(32'h0000_1000, 3'b000);
    mem_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_ready = 1'b1;
    chk("flush_req.ready", 32'(req_ready), 32'd1);
    chk("flush_req.no_mem", 32'(mem_req_valid), 32'd0);

    // stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("idle_rv.no_valid", 32'(result_valid), 32'd0);
    chk("idle_rv.ready", 32'(req_ready), 32'd1);
    run_vec(100, tbl[12]);

    // asynchronous reset while in REQ1
    start_req(32'h0000_3002, 3'b000);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rst_req1.valid", 32'(mem_req_valid), 32'd1);
    chk("rst_req1.addr", mem_addr, 32'h0000_3004);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req1.mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req1.mem_addr", mem_addr, 32'd0);
    chk("rst_req1.ready", 32'(req_ready), 32'd1);
    chk("rst_req1.result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_vec(101, tbl[3]);

    // MISALIGNED_EN=0: boundary crossing faults without touching memory
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 32'h0000_1001; b_width = 3'b000;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("nomis.valid", 32'(b_result_valid), 32'd1);
    chk("nomis.fault", 32'(b_fault), 32'd1);
    chk("nomis.result", b_result, 32'd0);
    chk("nomis.no_mem", 32'(b_mem_req_valid), 32'd0);
    chk("nomis.misaligned", 32'(b_mis), 32'd0);
    @(posedge clk); #1;
    chk("nomis.pulse", 32'(b_result_valid), 32'd0);
    chk("nomis.ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 32'h0000_1004; b_width = 3'b000; b_mem_ready = 1'b0;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("nomis.aligned_req", 32'(b_mem_req_valid), 32'd1);
    chk("nomis.aligned_addr", b_mem_addr, 32'h0000_1004);
    chk("nomis.aligned_novalid", 32'(b_result_valid), 32'd0);
    b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0; b_mem_ready = 1'b1;
    chk("nomis.flush_ready", 32'(b_req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised, sequential load-data formatter replacing the combinational load-width reduction in the MEM stage. It accepts one load request at a time and issues one or two aligned reads to the data-memory port. A second read is issued only when the access straddles an XLEN boundary. The unit merges the returned words, extracts the addressed bytes, sign- or zero-extends them, and presents a registered result with a valid pulse to writeback.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- MISALIGNED_EN, 1: 1 splits boundary-crossing loads into two reads; 0 reports them as faults.
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  1  load request valid.
- req_ready_o  out  1  unit can accept a request; high only in IDLE.
- req_addr_i  in  XLEN  byte address of the load.
- width_src_i  in  3  load type:
  - 000 word
  - 010 half signed
  - 110 half unsigned
  - 001 byte signed
  - 101 byte unsigned
  - 011 double (XLEN=64 only)
  - 100 word unsigned (XLEN=64 only)
- flush_i  in  1  synchronous abort of the current load.
- mem_req_valid_o  out  1  aligned read request valid.
- mem_req_ready_i  in  1  memory accepts the read.
- mem_addr_o  out  XLEN  aligned read address; low log2(XLEN/8) bits are always 0.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  XLEN  read data.
- result_valid_o  out  1  one-cycle pulse; result_o and fault_o are valid.
- result_o  out  XLEN  extended load result, registered.
- fault_o  out  1  illegal width, or misaligned access with MISALIGNED_EN=0; qualified by result_valid_o.
- misaligned_o  out  1  the load used two reads; qualified by result_valid_o.

## Operation
- **Reset.** reset_n_i low forces the following, regardless of any in-flight transaction:
  - state = IDLE;
  - result_valid_o, fault_o, misaligned_o, mem_req_valid_o = 0;
  - result_o = 0, mem_addr_o = 0.
- **States:** IDLE, REQ0, RSP0, REQ1, RSP1, DONE, DRAIN.
- **IDLE.** On req_valid_i && req_ready_o, latch address, width and offset = addr[log2(XLEN/8)-1:0]. Next state:
  - illegal width → DONE with fault;
  - offset+size > XLEN/8 and MISALIGNED_EN=0 → DONE with fault;
  - otherwise → REQ0.
- **REQ0.** mem_req_valid_o=1, mem_addr_o = addr with low bits cleared. On mem_req_ready_i → RSP0.
- **RSP0.** On mem_rvalid_i, capture word0. Next state is REQ1 if offset+size > XLEN/8, else DONE.
- **REQ1.** mem_addr_o = aligned addr + XLEN/8, wrapping modulo 2^XLEN. On mem_req_ready_i → RSP1.
- **RSP1.** On mem_rvalid_i, capture word1 → DONE.
- **Assembly.** Take {word1, word0} (word1 = 0 when not split), shift right by offset*8, keep the low size bytes.
  - Signed types replicate the top kept bit.
  - Unsigned types zero-fill.
- **Fault results:** result_o=0, fault_o=1, and no memory request is issued.
- **DONE.** result_valid_o=1 for exactly one cycle → IDLE. result_o holds until the next DONE.
- **flush_i behaviour** (ignored in IDLE and DONE):
  - in REQ0 or REQ1 → IDLE;
  - in RSP0 or RSP1 → DRAIN.
  - No result_valid_o is produced for a flushed load.
- **DRAIN.** Wait for mem_rvalid_i, discard the data → IDLE.
- mem_rvalid_i outside RSP0, RSP1 and DRAIN is ignored.
- flush_i in the same cycle as mem_rvalid_i in RSPx: the flush wins, the data is discarded, and the next state is IDLE.

## Timing
- Request accepted at edge T. REQ0 occupies cycle T+1.
- Best case (mem_req_ready_i high in REQ, mem_rvalid_i high the first RSP cycle):
  - aligned load: result_valid_o in cycle T+3;
  - split load: result_valid_o in cycle T+5;
  - faulted request: result_valid_o in cycle T+1.
- Each cycle of mem_req_ready_i low or of mem_rvalid_i delay adds one cycle.
- At most one outstanding memory read. mem_req_valid_o stays asserted with a stable address until accepted.
- req_ready_o returns high the cycle after DONE or DRAIN completes. There is no back-to-back acceptance in DONE.

## Test plan
- **Aligned word.** XLEN=32, lw at 0x1000, rdata 0xDEADBEEF → one read at 0x1000, result_o 0xDEADBEEF at T+3, fault_o=0, misaligned_o=0.
- **Byte extension.** lb then lbu at 0x1003, rdata 0x80FF1234 → 0xFFFFFF80, then 0x00000080.
- **Split word.** lw at 0x1002, word0 0x44332211, word1 0x88776655 → reads at 0x1000 then 0x1004; result 0x66554433, misaligned_o=1, valid at T+5.
- **Split half and wrap.**
  - lh at 0x1003, words 0x44332211 / 0x887766F5 → 0xFFFFF544; lhu → 0x0000F544.
  - lw at 0xFFFFFFFE → second read at 0x00000000.
- **Faults.**
  - Width 011 at XLEN=32 → no mem_req_valid_o; fault_o=1, result_o=0 at T+1.
  - MISALIGNED_EN=0, lw at 0x1001 → same fault response.
- **Flush and reset.**
  - flush_i in RSP0, rvalid 2 cycles later → no result_valid_o; req_ready_o high the cycle after rvalid.
  - reset_n_i low in REQ1 → mem_req_valid_o=0 immediately, state IDLE.
